// File: rtl/class_lu_key_sched.sv
// Lookup key scheduler: buffers full-width keys and serialises each into three
// bus beats toward classifier port A, capping outstanding lookups.
module class_lu_key_sched #(
  parameter int unsigned KEY_LEN      = 276,
  parameter int unsigned BUS_WIDTH    = 128,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MAX_INFLIGHT = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld,
  input  logic [KEY_LEN-1:0]   req_key,
  output logic                 req_rdy,
  output logic                 lu_vld,
  output logic [BUS_WIDTH-1:0] lu_key,
  input  logic                 lu_done,
  output logic [5:0]           inflight,
  output logic                 err_underflow
);

  localparam int unsigned TAIL_W = KEY_LEN - 2 * BUS_WIDTH;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W  = 6;

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [KEY_LEN-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 req_rdy_q, req_rdy_d;
  logic                 lu_vld_q, lu_vld_d;
  logic [BUS_WIDTH-1:0] lu_key_q, lu_key_d;
  logic [INF_W-1:0]     inflight_q, inflight_d;
  logic                 err_q, err_d;
  logic                 push, pop, enter_b0, eligible;
  logic [KEY_LEN-1:0]   head_key;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = req_vld && req_rdy_q;
  // An empty buffer forwards the incoming key so a fresh key issues next cycle.
  assign head_key = (count_q == '0) ? req_key : mem_q[rd_ptr_q];
  assign eligible = (push || (count_q != '0)) &&
                    ((inflight_q < INF_W'(MAX_INFLIGHT)) || lu_done);

  // Key storage; data is not reset, only the pointers and count are.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_key;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      req_rdy_q  <= 1'b1;
      lu_vld_q   <= 1'b0;
      lu_key_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      req_rdy_q  <= req_rdy_d;
      lu_vld_q   <= lu_vld_d;
      lu_key_q   <= lu_key_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Next state, next registered beat, FIFO and inflight bookkeeping.
  always_comb begin
    state_d    = state_q;
    lu_vld_d   = 1'b0;
    lu_key_d   = '0;
    pop        = 1'b0;
    enter_b0   = 1'b0;
    inflight_d = inflight_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_GAP: begin
        if (eligible) begin
          state_d  = S_B0;
          enter_b0 = 1'b1;
          lu_vld_d = 1'b1;
          lu_key_d = head_key[KEY_LEN-1 -: BUS_WIDTH];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_B0: begin
        state_d  = S_B1;
        lu_key_d = head_key[KEY_LEN-BUS_WIDTH-1 -: BUS_WIDTH];
      end
      S_B1: begin
        state_d  = S_B2;
        lu_key_d = {head_key[TAIL_W-1:0], {(BUS_WIDTH-TAIL_W){1'b0}}};
      end
      S_B2: begin
        state_d = S_GAP;
        pop     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    case ({enter_b0, lu_done})
      2'b10: inflight_d = inflight_q + INF_W'(1);
      2'b01: begin
        if (inflight_q == '0) err_d = 1'b1;
        else                  inflight_d = inflight_q - INF_W'(1);
      end
      default: inflight_d = inflight_q;
    endcase

    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    req_rdy_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  assign req_rdy       = req_rdy_q;
  assign lu_vld        = lu_vld_q;
  assign lu_key        = lu_key_q;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_class_lu_key_sched.sv
// Scoreboard bench for class_lu_key_sched: stimulus queues expected beats,
// a negedge monitor checks every beat the scheduler presents.
module tb_class_lu_key_sched;

  localparam int unsigned KEY_LEN = 276;
  localparam int unsigned BUS_W   = 128;

  typedef struct {
    logic [127:0] top;
    logic [127:0] mid;
    logic [19:0]  low;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_vld = 1'b0;
  logic [KEY_LEN-1:0] req_key = '0;
  logic               req_rdy;
  logic               lu_vld;
  logic [BUS_W-1:0]   lu_key;
  logic               lu_done = 1'b0;
  logic [5:0]         inflight;
  logic               err_underflow;

  class_lu_key_sched #(
    .KEY_LEN(276), .BUS_WIDTH(128), .FIFO_DEPTH(4), .MAX_INFLIGHT(26)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_key(req_key),
    .req_rdy(req_rdy), .lu_vld(lu_vld), .lu_key(lu_key),
    .lu_done(lu_done), .inflight(inflight), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  int   vld_cyc[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int i);
    vec_t v;
    v.top = {4{32'hA000_0000 | 32'(i)}};
    v.mid = {4{32'h5000_0000 | 32'(i)}};
    v.low = 20'hC0000 | 20'(i);
    return v;
  endfunction

  function automatic logic [KEY_LEN-1:0] key_of(input vec_t v);
    return {v.top, v.mid, v.low};
  endfunction

  // Monitor: each lu_vld pulse starts a three-beat lookup taken from the scoreboard.
  initial begin : monitor
    int   beat;
    vec_t cur;
    beat = 0;
    forever begin
      @(negedge clk);
      if (rst_seen !== 1'b0) begin
        beat = 0;
        exp_q.delete();
      end else if (beat == 0) begin
        if (lu_vld === 1'b1) begin
          vld_cyc.push_back(cyc);
          chk("lu_vld_expected", 128'(exp_q.size() != 0), 128'(1));
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("beat0_key", lu_key, cur.top);
            beat = 1;
          end
        end else begin
          chk("idle_key_zero", lu_key, 128'(0));
        end
      end else if (beat == 1) begin
        chk("beat1_vld", 128'(lu_vld), 128'(0));
        chk("beat1_key", lu_key, cur.mid);
        beat = 2;
      end else begin
        chk("beat2_vld", 128'(lu_vld), 128'(0));
        chk("beat2_key", lu_key, {cur.low, 108'h0});
        beat = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds the key until accepted, returns the accept cycle.
  task automatic push_key(input vec_t v, output int t);
    int n;
    n = 0;
    req_vld = 1'b1;
    req_key = key_of(v);
    while (req_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", 128'(req_rdy), 128'(1));
    t = cyc;
    if (req_rdy === 1'b1) exp_q.push_back(v);
    @(negedge clk);
  endtask

  task automatic wait_vld(input int n, input int budget);
    int k;
    k = 0;
    while (vld_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("vld_count", 128'(vld_cyc.size()), 128'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   t [5];
    int   t0;
    vec_t v0;

    // Reset state
    tick(3);
    chk("rst_lu_vld", 128'(lu_vld), 128'(0));
    chk("rst_lu_key", lu_key, 128'(0));
    chk("rst_inflight", 128'(inflight), 128'(0));
    chk("rst_err", 128'(err_underflow), 128'(0));
    chk("rst_req_rdy", 128'(req_rdy), 128'(1));
    rst = 1'b0;
    tick(2);

    // Single key, latency 1
    v0.top = 128'h12345678_9ABCDEF0_13579BDF_2468ACE0;
    v0.mid = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    v0.low = 20'hABCDE;
    vld_cyc.delete();
    push_key(v0, t0);
    req_vld = 1'b0;
    wait_vld(1, 20);
    if (vld_cyc.size() >= 1) chk("single_latency", 128'(vld_cyc[0]), 128'(t0 + 1));
    tick(4);
    chk("single_inflight", 128'(inflight), 128'(1));
    lu_done = 1'b1;
    tick(1);
    lu_done = 1'b0;
    chk("single_done_inflight", 128'(inflight), 128'(0));
    chk("single_no_err", 128'(err_underflow), 128'(0));

    // Five keys back-to-back: period 4, buffer full once the fifth lands
    vld_cyc.delete();
    for (int i = 0; i < 5; i++) push_key(mk(i), t[i]);
    chk("b2b_accept_cycle", 128'(t[4]), 128'(t[0] + 4));
    chk("b2b_rdy_full", 128'(req_rdy), 128'(0));
    req_vld = 1'b0;
    wait_vld(5, 40);
    for (int i = 0; i < 5; i++)
      if (vld_cyc.size() > i) chk("b2b_vld_cycle", 128'(vld_cyc[i]), 128'(t[0] + 1 + 4 * i));
    tick(4);
    chk("b2b_inflight", 128'(inflight), 128'(5));
    chk("b2b_sb_empty", 128'(exp_q.size()), 128'(0));
    lu_done = 1'b1;
    tick(5);
    lu_done = 1'b0;
    tick(1);
    chk("b2b_drain", 128'(inflight), 128'(0));

    // lu_done coincident with B0 entry at inflight 3
    vld_cyc.delete();
    for (int i = 0; i < 3; i++) push_key(mk(10 + i), t[i]);
    req_vld = 1'b0;
    wait_vld(3, 40);
    tick(4);
    chk("coin_pre_inflight", 128'(inflight), 128'(3));
    lu_done = 1'b1;
    push_key(mk(20), t0);
    lu_done = 1'b0;
    req_vld = 1'b0;
    chk("coin_inflight", 128'(inflight), 128'(3));
    wait_vld(4, 10);
    if (vld_cyc.size() >= 4) chk("coin_vld_cycle", 128'(vld_cyc[3]), 128'(t0 + 1));
    tick(4);
    chk("coin_inflight_hold", 128'(inflight), 128'(3));
    lu_done = 1'b1;
    tick(3);
    lu_done = 1'b0;
    tick(1);
    chk("coin_drain", 128'(inflight), 128'(0));

    // Underflow is sticky and inflight stays at 0
    lu_done = 1'b1;
    tick(1);
    lu_done = 1'b0;
    chk("uf_err", 128'(err_underflow), 128'(1));
    chk("uf_inflight", 128'(inflight), 128'(0));
    tick(5);
    chk("uf_err_sticky", 128'(err_underflow), 128'(1));

    // 27 keys without completions: stall at 26, one lu_done releases the 27th
    vld_cyc.delete();
    for (int i = 0; i < 27; i++) push_key(mk(30 + i), t0);
    req_vld = 1'b0;
    wait_vld(26, 200);
    tick(12);
    chk("max_vld_count", 128'(vld_cyc.size()), 128'(26));
    chk("max_inflight", 128'(inflight), 128'(26));
    chk("max_stall_vld", 128'(lu_vld), 128'(0));
    chk("max_err_sticky", 128'(err_underflow), 128'(1));
    lu_done = 1'b1;
    t0 = cyc;
    tick(1);
    lu_done = 1'b0;
    chk("max_release_vld", 128'(lu_vld), 128'(1));
    chk("max_release_inflight", 128'(inflight), 128'(26));
    wait_vld(27, 5);
    if (vld_cyc.size() >= 27) chk("max_release_cycle", 128'(vld_cyc[26]), 128'(t0 + 1));
    tick(4);

    // Reset clears the sticky error
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("rst2_err", 128'(err_underflow), 128'(0));
    chk("rst2_inflight", 128'(inflight), 128'(0));

    // Reset in B1 with two keys buffered
    vld_cyc.delete();
    push_key(mk(60), t[0]);
    push_key(mk(61), t[1]);
    req_vld = 1'b0;
    chk("mid_in_b1", lu_key, mk(60).mid);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_vld", 128'(lu_vld), 128'(0));
    chk("mid_rst_key", lu_key, 128'(0));
    chk("mid_rst_inflight", 128'(inflight), 128'(0));
    chk("mid_rst_rdy", 128'(req_rdy), 128'(1));
    chk("mid_rst_err", 128'(err_underflow), 128'(0));
    rst = 1'b0;
    vld_cyc.delete();
    tick(20);
    chk("mid_no_residual", 128'(vld_cyc.size()), 128'(0));
    chk("mid_idle_key", lu_key, 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
